// File: rtl/king_escape_scanner.sv
`default_nettype none
// ============================================================================
// Module   : king_escape_scanner
// Purpose  : Time-shares one external check evaluator to classify a king.
//            Evaluates the king's current square, then a trial board for each
//            of the 8 adjacent king moves, and reports check status, an
//            escape mask, its popcount and a trapped flag.
// Ports    : clk_i, rst_ni        - clock, asynchronous active-low reset
//            start_i, is_white_i  - scan request and side (accepted in IDLE)
//            board_in_i           - 12 x 64-bit bitboards, slice k at [64k+:64]
//            eval_board_o,
//            eval_is_white_o      - registered board/side to the evaluator
//            eval_in_check_i      - evaluator result
//            busy_o, done_o       - scan in progress / results-valid pulse
//            no_king_o, in_check_o, escape_mask_o, escape_count_o,
//            king_trapped_o       - scan results, held until next start
// Revision : 1.0 - initial release
// ============================================================================
module king_escape_scanner #(
  parameter int EVAL_WAIT = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         is_white_i,
  input  logic [767:0] board_in_i,
  output logic [767:0] eval_board_o,
  output logic         eval_is_white_o,
  input  logic         eval_in_check_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         no_king_o,
  output logic         in_check_o,
  output logic [7:0]   escape_mask_o,
  output logic [3:0]   escape_count_o,
  output logic         king_trapped_o
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOAD        = 3'd1,
    S_CUR_DRIVE   = 3'd2,
    S_CUR_SAMPLE  = 3'd3,
    S_CAND_DRIVE  = 3'd4,
    S_CAND_SAMPLE = 3'd5,
    S_DONE        = 3'd6
  } state_t;

  localparam logic [1:0] C_WAIT_LAST = 2'(EVAL_WAIT - 1);

  state_t         state_q;
  logic [767:0]   board_q;
  logic           is_white_q;
  logic [2:0]     king_file_q;
  logic [2:0]     king_rank_q;
  logic [2:0]     d_q;
  logic [1:0]     wait_q;
  logic           cand_valid_q;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
    return n;
  endfunction

  // King finder: lowest set bit of the selected king slice.
  logic [63:0] w_king_slice;
  logic [5:0]  w_king_idx;
  always_comb begin
    w_king_slice = is_white_q ? board_q[704 +: 64] : board_q[320 +: 64];
    w_king_idx   = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if (w_king_slice[i]) w_king_idx = 6'(i);
    end
  end

  // The trial board is registered one cycle before its DRIVE state, so while
  // sampling direction d the builder is already producing direction d+1.
  logic [2:0]        w_dir;
  logic signed [4:0] w_df, w_dr, w_dst_f, w_dst_r;
  logic              w_in_range, w_valid;
  logic [5:0]        w_dest_idx;
  logic [63:0]       w_dest, w_origin, w_friend_occ;
  logic [767:0]      w_trial;

  always_comb begin
    w_dir = (state_q == S_CAND_SAMPLE) ? d_q + 3'd1 : d_q;
    w_df  = 5'sd0;
    w_dr  = 5'sd0;
    case (w_dir)
      3'd0: begin w_df =  5'sd0; w_dr =  5'sd1; end  // N
      3'd1: begin w_df =  5'sd1; w_dr =  5'sd1; end  // NE
      3'd2: begin w_df =  5'sd1; w_dr =  5'sd0; end  // E
      3'd3: begin w_df =  5'sd1; w_dr = -5'sd1; end  // SE
      3'd4: begin w_df =  5'sd0; w_dr = -5'sd1; end  // S
      3'd5: begin w_df = -5'sd1; w_dr = -5'sd1; end  // SW
      3'd6: begin w_df = -5'sd1; w_dr =  5'sd0; end  // W
      default: begin w_df = -5'sd1; w_dr = 5'sd1; end // NW
    endcase
    w_dst_f    = $signed({2'b00, king_file_q}) + w_df;
    w_dst_r    = $signed({2'b00, king_rank_q}) + w_dr;
    w_in_range = (w_dst_f >= 5'sd0) && (w_dst_f <= 5'sd7) &&
                 (w_dst_r >= 5'sd0) && (w_dst_r <= 5'sd7);
    w_dest_idx = {w_dst_r[2:0], w_dst_f[2:0]};
    w_dest     = 64'd1 << w_dest_idx;
    w_origin   = 64'd1 << {king_rank_q, king_file_q};

    w_friend_occ = '0;
    for (int k = 0; k < 6; k++) begin
      w_friend_occ = w_friend_occ |
                     (is_white_q ? board_q[64*(k+6) +: 64] : board_q[64*k +: 64]);
    end
    w_valid = w_in_range && !w_friend_occ[w_dest_idx];

    // Move the friendly king, capture whatever enemy piece sits on the
    // destination; invalid candidates keep the untouched board.
    w_trial = board_q;
    if (w_valid) begin
      for (int k = 0; k < 12; k++) begin
        if ((k >= 6) == is_white_q) begin
          if (k == 5 || k == 11)
            w_trial[64*k +: 64] = (board_q[64*k +: 64] & ~w_origin) | w_dest;
        end else begin
          w_trial[64*k +: 64] = board_q[64*k +: 64] & ~w_dest;
        end
      end
    end
  end

  logic [7:0] w_mask_next;
  assign w_mask_next = escape_mask_o |
                       ({7'b0, cand_valid_q & ~eval_in_check_i} << d_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= S_IDLE;
      board_q         <= '0;
      is_white_q      <= 1'b0;
      king_file_q     <= 3'd0;
      king_rank_q     <= 3'd0;
      d_q             <= 3'd0;
      wait_q          <= 2'd0;
      cand_valid_q    <= 1'b0;
      eval_board_o    <= '0;
      eval_is_white_o <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      no_king_o       <= 1'b0;
      in_check_o      <= 1'b0;
      escape_mask_o   <= 8'd0;
      escape_count_o  <= 4'd0;
      king_trapped_o  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            board_q        <= board_in_i;
            is_white_q     <= is_white_i;
            escape_mask_o  <= 8'd0;
            escape_count_o <= 4'd0;
            in_check_o     <= 1'b0;
            no_king_o      <= 1'b0;
            king_trapped_o <= 1'b0;
            busy_o         <= 1'b1;
            state_q        <= S_LOAD;
          end
        end
        S_LOAD: begin
          king_file_q <= w_king_idx[2:0];
          king_rank_q <= w_king_idx[5:3];
          if (w_king_slice == 64'd0) begin
            no_king_o <= 1'b1;
            done_o    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            d_q             <= 3'd0;
            wait_q          <= 2'd0;
            eval_board_o    <= board_q;
            eval_is_white_o <= is_white_q;
            state_q         <= S_CUR_DRIVE;
          end
        end
        S_CUR_DRIVE, S_CAND_DRIVE: begin
          if (wait_q == C_WAIT_LAST) begin
            wait_q  <= 2'd0;
            state_q <= (state_q == S_CUR_DRIVE) ? S_CUR_SAMPLE : S_CAND_SAMPLE;
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end
        S_CUR_SAMPLE: begin
          in_check_o   <= eval_in_check_i;
          eval_board_o <= w_trial;
          cand_valid_q <= w_valid;
          state_q      <= S_CAND_DRIVE;
        end
        S_CAND_SAMPLE: begin
          escape_mask_o <= w_mask_next;
          if (d_q == 3'd7) begin
            escape_count_o <= popcnt8(w_mask_next);
            king_trapped_o <= in_check_o && (w_mask_next == 8'd0);
            done_o         <= 1'b1;
            state_q        <= S_DONE;
          end else begin
            d_q          <= d_q + 3'd1;
            eval_board_o <= w_trial;
            cand_valid_q <= w_valid;
            state_q      <= S_CAND_DRIVE;
          end
        end
        S_DONE: begin
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/king_escape_scanner.md
# king_escape_scanner

Sequential controller that time-shares one combinational check evaluator (768-bit board in, `is_in_check` out) to classify a king's position. On `start` it latches a board and side. It locates that side's king and evaluates the king's current square. It then builds and evaluates a trial board for each of the 8 adjacent king moves. It reports check status, an escape mask and a trapped flag to the move/game-state logic.

## Interface
Parameters:
- `EVAL_WAIT`, default 1: idle cycles between driving `eval_board` and sampling `eval_in_check`. Legal values are 1–3. All timing below assumes 1.

Ports:
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request a scan. Accepted only in IDLE.
- `is_white`  input  1  side to scan. 1 selects the white king (board slice 11); 0 selects the black king (slice 5).
- `board_in`  input  768  twelve 64-bit bitboards, slice k at [64k +: 64].
  - Slices 0–5: black pawn, knight, bishop, rook, queen, king.
  - Slices 6–11: white, same piece order.
  - Square index = rank*8 + file.
- `eval_board`  output  768  trial board driven to the evaluator. Registered.
- `eval_is_white`  output  1  side driven to the evaluator. Registered.
- `eval_in_check`  input  1  evaluator result.
- `busy`  output  1  high from the cycle after `start` is accepted until `done`, inclusive.
- `done`  output  1  one-cycle pulse when results are valid.
- `no_king`  output  1  the selected king bitboard was zero.
- `in_check`  output  1  the king is attacked on its current square.
- `escape_mask`  output  8  bit d = 1 if move direction d is legal and not into check.
  - Direction order, d = 0..7: N(+8), NE(+9), E(+1), SE(−7), S(−8), SW(−9), W(−1), NW(+7).
- `escape_count`  output  4  popcount of `escape_mask`.
- `king_trapped`  output  1  `in_check` & (`escape_count` == 0).

## Operation
- States: IDLE, LOAD, CUR_DRIVE, CUR_SAMPLE, CAND_DRIVE, CAND_SAMPLE, DONE.
- **IDLE**
  - When `start` = 1, latch `board_in` and `is_white`.
  - Clear `escape_mask`, `in_check`, `no_king` and `king_trapped`.
  - Go to LOAD.
- **LOAD**
  - Locate the king at the lowest set bit of its slice and register it as (file, rank).
  - If the slice is zero: set `no_king` and go to DONE.
  - Otherwise set d = 0 and go to CUR_DRIVE.
- **CUR_DRIVE**: `eval_board` = latched board; `eval_is_white` = latched side. Then CUR_SAMPLE.
- **CUR_SAMPLE**: `in_check` ← `eval_in_check`. Then CAND_DRIVE.
- **CAND_DRIVE (direction d)**
  - The candidate is valid iff the destination file and rank are both in 0..7 (no wrap across board edges) and no friendly slice is set at the destination.
  - Trial board: clear the king's origin bit and set the destination bit in the king slice.
  - Clear the destination bit in all six enemy slices (capture).
  - Friendly non-king slices are unchanged.
  - For an invalid candidate, drive the unmodified latched board. The evaluator still runs, but the result is ignored.
- **CAND_SAMPLE**
  - `escape_mask[d]` ← valid & ~`eval_in_check`.
  - If d == 7, go to DONE. Otherwise d ← d+1 and go to CAND_DRIVE.
- **DONE**
  - Pulse `done`.
  - `escape_count` and `king_trapped` become valid on the same cycle as `done`.
  - Go to IDLE.
- Results hold until the next accepted `start`.
- `start` while busy is ignored. No queuing.
- Latency does not depend on board contents. Invalid candidates still take 2 cycles.

## Timing
- Reset values:
  - `eval_board` = 0, `eval_is_white` = 0.
  - All status outputs = 0; state = IDLE; d = 0.
- Cycle numbering: `start` is sampled at edge 0.
  - LOAD occupies cycle 1.
  - Current-square evaluation occupies cycles 2–3.
  - Candidate d occupies cycles 4+2d and 5+2d.
  - `done` is high in cycle 20. `busy` is high in cycles 1–20.
- No-king path: `done` in cycle 2; all other results 0.
- `start` asserted in the DONE cycle is ignored. The next scan can be accepted in cycle 21.
- Reset asserted mid-scan: immediately returns to IDLE with reset values. No `done` is issued.
- The evaluator result is sampled `EVAL_WAIT` cycles after `eval_board` changes. For `EVAL_WAIT` > 1, each DRIVE state is extended by `EVAL_WAIT`−1 cycles.

## Test plan
- **Lone kings**: white king at bit 4, black king at bit 60, `is_white` = 1 → `in_check` = 0, `escape_mask` = 0xC7, `escape_count` = 5, `done` in cycle 20.
- **Back rank**: white king at 6, white pawns at 13/14/15, black rook at 0, black king at 60 → `in_check` = 1, mask 0x00, `king_trapped` = 1.
- **Capture escape**: white king at 0, lone black queen at 9, black king at 63 → `in_check` = 1, mask 0x02, count 1. During cycle 7, `eval_board` slice 4 = 0 and slice 11 bit 9 = 1.
- **Edge wrap**: white king at 7, black king at 56 → mask 0xC1. The E candidate (bit 8) must not be evaluated as valid.
- **No king**: `is_white` = 0 with slice 5 = 0 → `no_king` = 1 and `done` in cycle 2; mask 0.
- **Protocol**: `start` re-asserted in cycles 5 and 20 → ignored. Repeat the lone-kings scan and pull `rst_n` low in cycle 10 → all outputs 0 immediately and no `done`. A new `start` after reset completes normally.
